// File: rtl/bin_to_bcd_feeder.sv
// Binary-to-BCD converter that loads an 8-digit display serializer.
// Latency: 28 cycles from accepted start to data/lockdata, then lockdata held LOCK_HOLD cycles.
// Backpressure: none queued; start is only sampled while idle, busy flags when it is ignored.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start, bin      conversion request and 27-bit unsigned value, captured together
//   data            packed BCD, digit 7 in [31:28], held stable until the next load
//   lockdata        serializer load strobe, high for LOCK_HOLD cycles after each load
//   busy            high whenever a request is in progress
//   ovf             last accepted value exceeded 99999999 (data shows 99999999)
//
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits (never digit 0) are
// loaded as 4'hF, the serializer's blank code. Timing is identical either way.
module bin_to_bcd_feeder #(
   parameter int LOCK_HOLD = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [26:0] bin,
   output logic [31:0] data,
   output logic        lockdata,
   output logic        busy,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [26:0] work;       // binary bits still to be shifted in, MSB first
   logic [31:0] acc;        // BCD accumulator
   logic [31:0] acc_adj;    // accumulator after the add-3 correction
   logic [31:0] load_val;   // value presented to data at LOAD
   logic [4:0]  iter_cnt;
   logic [3:0]  hold_cnt;
   logic        ovf_pend;   // overflow decision made on the captured value

   // Per-digit add-3 correction applied before each shift.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 8; i++) begin
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lead;
   // Blank zeros above the most significant nonzero digit; digit 0 always shows.
   always_comb begin
      load_val = acc;
      lead     = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         if (lead && (acc[4*i +: 4] == 4'd0))
            load_val[4*i +: 4] = 4'hF;
         else
            lead = 1'b0;
      end
   end
`else
   always_comb begin
      load_val = acc;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CONV;
         CONV: if (iter_cnt == 5'd26) state_nxt = LOAD;
         LOAD: state_nxt = HOLD;
         HOLD: if (hold_cnt == 4'(LOCK_HOLD - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work     <= '0;
         acc      <= '0;
         iter_cnt <= '0;
         hold_cnt <= '0;
         ovf_pend <= 1'b0;
         data     <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work     <= bin;
                  acc      <= '0;
                  iter_cnt <= '0;
                  ovf_pend <= (bin > 27'd99999999);
               end
            end
            CONV: begin
               {acc, work} <= {acc_adj[30:0], work, 1'b0};
               iter_cnt    <= iter_cnt + 5'd1;
            end
            LOAD: begin
               // Overflow display is fixed and bypasses blanking.
               data     <= ovf_pend ? 32'h99999999 : load_val;
               ovf      <= ovf_pend;
               hold_cnt <= '0;
            end
            HOLD: begin
               hold_cnt <= hold_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Both strobes are pure decodes of the state register, so reset clears them at once.
   assign lockdata = (state == HOLD);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_feeder.sv
// Self-checking bench for bin_to_bcd_feeder: directed cases plus random values.
// Latency: checks every cycle of each request against an arithmetic decimal model.
// Backpressure: exercises ignored starts, held-high starts and mid-request reset.
module tb_bin_to_bcd_feeder;

   localparam int L = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [26:0] bin;
   logic [31:0] data;
   logic        lockdata;
   logic        busy;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   logic [31:0] prev_data = '0;
   logic        prev_ovf  = 1'b0;

   bin_to_bcd_feeder #(.LOCK_HOLD(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin      (bin),
      .data     (data),
      .lockdata (lockdata),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Decimal digits by division; leading-zero digit d is blank when v < 10^d.
   function automatic logic [31:0] model(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      int unsigned p;
      if (v > 99999999) return 32'h99999999;
      r = '0;
      x = v;
      for (int d = 0; d < 8; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef LEADING_ZERO_BLANK_EN
      p = 1;
      for (int d = 1; d < 8; d++) begin
         p = p * 10;
         if (v < p) r[4*d +: 4] = 4'hF;
      end
`else
      p = 0;
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed={busy,lock,ovf,data}=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One request accepted at the next edge N. keep leaves start high afterwards;
   // glitch_k>0 pulses start with bin=222 so that edge N+glitch_k samples it.
   task automatic run(input string tag, input logic [26:0] v, input bit keep, input int glitch_k);
      logic [31:0] nd;
      logic        no;
      logic [31:0] ed;
      logic        eo;
      nd = model(int'(v));
      no = (v > 27'd99999999);
      start = 1'b1;
      bin   = v;
      for (int k = 0; k <= 28 + L; k++) begin
         tick();
         ed = (k >= 28) ? nd : prev_data;
         eo = (k >= 28) ? no : prev_ovf;
         check(tag, {busy, lockdata, ovf, data},
               {(k < 28 + L), (k >= 28 && k < 28 + L), eo, ed});
         // Inputs after edge N must not influence the result.
         start = keep;
         bin   = 27'($urandom);
         if (glitch_k > 0 && k == glitch_k - 1) begin
            start = 1'b1;
            bin   = 27'd222;
         end
      end
      prev_data = nd;
      prev_ovf  = no;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      #2;
      check("reset_state", {busy, lockdata, ovf, data}, 35'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_after_reset", {busy, lockdata, ovf, data}, 35'd0);

      run("bin_12345678", 27'd12345678, 1'b0, 0);
      run("bin_0", 27'd0, 1'b0, 0);
      run("bin_99999999", 27'd99999999, 1'b0, 0);
      run("bin_1234", 27'd1234, 1'b0, 0);
      run("bin_100000000_ovf", 27'd100000000, 1'b0, 0);
      run("bin_5_after_ovf", 27'd5, 1'b0, 0);
      run("bin_max_ovf", 27'h7FFFFFF, 1'b0, 0);
      run("bin_111_ignored_222", 27'd111, 1'b0, 10);
      // Start pulsed on the HOLD->IDLE edge must be dropped.
      run("bin_7_late_start", 27'd7, 1'b0, 28 + L);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("no_extra_pulse", {busy, lockdata, ovf, data}, {1'b0, 1'b0, prev_ovf, prev_data});
      end

      // Start held high: the second request begins one cycle after IDLE.
      run("b2b_first", 27'd31415926, 1'b1, 0);
      run("b2b_second", 27'd27182818, 1'b0, 0);
      tick();

      // Reset during conversion, between clock edges.
      start = 1'b1;
      bin   = 27'd98765;
      tick();
      start = 1'b0;
      repeat (14) tick();
      #2 rst = 1'b1;
      #1;
      check("async_reset_mid_conv", {busy, lockdata, ovf, data}, 35'd0);
      prev_data = '0;
      prev_ovf  = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 35; k++) begin
         tick();
         check("abandoned_no_pulse", {busy, lockdata, ovf, data}, 35'd0);
      end
      run("bin_42_after_reset", 27'd42, 1'b0, 0);

      // Reset during HOLD also clears the strobe at once.
      start = 1'b1;
      bin   = 27'd8;
      repeat (30) tick();
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_reset_mid_hold", {busy, lockdata, ovf, data}, 35'd0);
      prev_data = '0;
      prev_ovf  = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         logic [26:0] r;
         if (i % 2 == 0) r = 27'($urandom_range(0, 99999999));
         else            r = 27'($urandom);
         if (i % 4 == 3) r = 27'($urandom_range(0, 999));
         run("random", r, 1'b0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bin_to_bcd_feeder.md
BIN_TO_BCD_FEEDER -- requirements
Module: bin_to_bcd_feeder

Interface
REQ-001 Parameter: LOCK_HOLD, default 5, number of clk cycles lockdata stays high per update (legal range 1..15).
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  request a conversion of bin; sampled on the rising edge.
REQ-005 Port: bin  input  27  unsigned binary value to display.
REQ-006 Port: data  output  32  packed BCD, 8 digits, digit 7 (most significant) in [31:28]; feeds the display serializer data input.
REQ-007 Port: lockdata  output  1  load strobe to the display serializer.
REQ-008 Port: busy  output  1  high while a request is being processed.
REQ-009 Port: ovf  output  1  high when the last accepted bin exceeded 99999999.

Function
REQ-010 The block SHALL use states IDLE, CONV, LOAD and HOLD.
REQ-011 IDLE with start=1 at edge N SHALL capture bin into a work register, clear the BCD accumulator and iteration counter, and enter CONV.
REQ-012 start while state != IDLE SHALL be ignored; no queuing; bin changes after edge N SHALL NOT affect the result.
REQ-013 CONV SHALL run exactly 27 shift-add-3 iterations, one per cycle, at edges N+1..N+27: each BCD digit >= 5 is incremented by 3, then the {accumulator, work} register shifts left 1 bit, taking in the binary MSB.
REQ-014 After iteration 27 (edge N+27), the state SHALL be LOAD.
REQ-015 At edge N+28 (LOAD), data SHALL take the converted value, ovf SHALL be updated, lockdata SHALL go to 1, and the state SHALL become HOLD.
REQ-016 Overflow: captured bin > 99999999 SHALL give data = 32'h99999999 with ovf=1; otherwise ovf=0.
REQ-017 lockdata SHALL stay high for exactly LOCK_HOLD cycles and fall at edge N+28+LOCK_HOLD, when the state returns to IDLE.
REQ-018 busy SHALL be 1 exactly when the state != IDLE (edges N+1 through N+28+LOCK_HOLD).
REQ-019 data and ovf SHALL hold their previous values throughout CONV, so the display never shows intermediate values.
REQ-020 start=1 at the same edge that HOLD returns to IDLE SHALL be ignored; a request is accepted only when sampled in IDLE.
REQ-021 Back-to-back requests: a start held high SHALL begin a new conversion one cycle after returning to IDLE.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, data=32'h0, lockdata=0, busy=0 and ovf=0, and clear the work register, accumulator and counters.
REQ-023 Reset asserted mid-CONV or mid-HOLD SHALL abandon the request; no lockdata pulse is produced for it.
REQ-024 After rst falls, the first start sampled in IDLE SHALL be accepted normally.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL replace every zero digit above the most significant nonzero digit with 4'hF (the serializer's blank code) in the data value loaded at LOAD.
REQ-026 Digit 0 SHALL never be blanked.
REQ-027 The overflow value SHALL be unaffected by blanking.
REQ-028 Without the macro, data SHALL carry plain BCD with leading zeros, and no blanking logic SHALL be synthesized.
REQ-029 Timing SHALL be identical with and without the macro.

Verification
REQ-030 After reset, pulse start at edge N with bin=12345678 -> data=32'h12345678 and lockdata rise at edge N+28, lockdata high 5 cycles, busy low at N+33, ovf=0.
REQ-031 bin=0, then bin=99999999 -> data=32'h00000000, then data=32'h99999999; ovf=0 both times; with LEADING_ZERO_BLANK_EN, bin=0 -> 32'hFFFFFFF0 and bin=1234 -> 32'hFFFF1234.
REQ-032 bin=100000000 -> data=32'h99999999, ovf=1; a following bin=5 -> data=32'h00000005, ovf=0.
REQ-033 Start bin=111 then pulse start with bin=222 at edge N+10 -> only one lockdata pulse, data=32'h00000111.
REQ-034 Assert rst at edge N+15 of a conversion -> outputs zero asynchronously; no lockdata pulse; a new start after release with bin=42 -> data=32'h00000042.
